// File: rtl/at_resp_decoder.sv
// at_resp_decoder: classifies modem AT response lines byte by byte without buffering the line.
// Keyword flags track prefix matches; the length test at CR separates exact keywords from prefix keywords.
module at_resp_decoder #(
    parameter int MAXLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       clear,
    output logic [2:0] ctrl,
    output logic [7:0] msg_no,
    output logic       line_done,
    output logic       ovf
);
    localparam int CW = $clog2(MAXLEN + 2);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [87:0] KW_OK   = 88'("OK");
    localparam logic [87:0] KW_ERR  = 88'("ERROR");
    localparam logic [87:0] KW_CMS  = 88'("+CMS ERROR:");
    localparam logic [87:0] KW_CPMS = 88'("+CPMS:");
    localparam logic [87:0] KW_CMTI = 88'("+CMTI:");

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  m_q, m_d, m_base;
    logic [1:0]  idx_cnt_q, idx_cnt_d, idx_base;
    logic [7:0]  idx_chr_q, idx_chr_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [7:0]  msg_q, msg_d;
    logic        line_done_q, line_done_d;
    logic        ovf_q, ovf_d;
    logic        fresh;
    int          pos;

    // Positions beyond the keyword length always match, so prefix flags survive.
    function automatic logic kw_ok(input logic [87:0] kw, input int len, input int p, input logic [7:0] c);
        if (p >= len) return 1'b1;
        return c == kw[8*(len-1-p) +: 8];
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_d         = m_q;
        idx_cnt_d   = idx_cnt_q;
        idx_chr_d   = idx_chr_q;
        ctrl_d      = clear ? 3'b000 : ctrl_q;
        msg_d       = msg_q;
        line_done_d = 1'b0;
        ovf_d       = 1'b0;
        fresh       = state_q == IDLE;
        pos         = fresh ? 0 : int'(cnt_q);
        m_base      = fresh ? 5'b11111 : m_q;
        idx_base    = fresh ? 2'd2 : idx_cnt_q;
        if (rx_valid && rx_data != LF) begin
            if (rx_data == CR) begin
                state_d = IDLE;
                if (state_q == COLLECT) begin
                    if (m_q[0] && pos == 2) begin
                        ctrl_d = 3'b001;
                        line_done_d = 1'b1;
                    end else if ((m_q[1] && pos == 5) || (m_q[2] && pos >= 11)) begin
                        ctrl_d = 3'b011;
                        line_done_d = 1'b1;
                    end else if (m_q[3] && pos >= 6) begin
                        ctrl_d = 3'b010;
                        line_done_d = 1'b1;
                    end else if (m_q[4] && pos >= 6) begin
                        line_done_d = 1'b1;
                        if (idx_cnt_q == 2'd1 && idx_chr_q >= "0" && idx_chr_q <= "9") begin
                            ctrl_d = 3'b100;
                            msg_d  = idx_chr_q;
                        end else begin
                            ctrl_d = 3'b101;
                        end
                    end
                end
            end else if (state_q != DISCARD) begin
                if (pos >= MAXLEN) begin
                    state_d = DISCARD;
                    cnt_d   = CW'(MAXLEN + 1);
                    ovf_d   = 1'b1;
                end else begin
                    state_d = COLLECT;
                    cnt_d   = CW'(pos + 1);
                    m_d     = m_base & {kw_ok(KW_CMTI, 6, pos, rx_data),
                                        kw_ok(KW_CPMS, 6, pos, rx_data),
                                        kw_ok(KW_CMS, 11, pos, rx_data),
                                        kw_ok(KW_ERR, 5, pos, rx_data),
                                        kw_ok(KW_OK, 2, pos, rx_data)};
                    // idx count 2 means "no comma yet or field too long" and saturates there.
                    idx_cnt_d = rx_data == "," ? 2'd0 : (idx_base == 2'd0 ? 2'd1 : 2'd2);
                    idx_chr_d = (rx_data != "," && idx_base == 2'd0) ? rx_data : idx_chr_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            idx_cnt_q   <= '0;
            idx_chr_q   <= '0;
            ctrl_q      <= '0;
            msg_q       <= '0;
            line_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            idx_cnt_q   <= idx_cnt_d;
            idx_chr_q   <= idx_chr_d;
            ctrl_q      <= ctrl_d;
            msg_q       <= msg_d;
            line_done_q <= line_done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign msg_no    = msg_q;
    assign line_done = line_done_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_at_resp_decoder.sv
// tb_at_resp_decoder: directed byte stream against a line-buffering reference model.
// Expected outputs are queued as each byte is driven and compared one edge later.
module tb_at_resp_decoder;
    localparam int MAXLEN = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] ctrl;
    logic [7:0] msg_no;
    logic       line_done;
    logic       ovf;

    typedef struct {
        logic [2:0] c;
        logic [7:0] m;
        logic       ld;
        logic       ov;
    } exp_t;

    exp_t  sb[$];
    int    compared = 0;
    int    mismatched = 0;
    string m_buf = "";
    bit    m_disc = 0;
    logic [2:0] m_ctrl = '0;
    logic [7:0] m_msg = '0;

    at_resp_decoder #(.MAXLEN(MAXLEN)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
        .ctrl(ctrl), .msg_no(msg_no), .line_done(line_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_empty_sb"}, 8'h01, 8'h00);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_ctrl"}, {5'b0, ctrl}, {5'b0, e.c});
        chk({tag, "_msg"}, msg_no, e.m);
        chk({tag, "_line_done"}, {7'b0, line_done}, {7'b0, e.ld});
        chk({tag, "_ovf"}, {7'b0, ovf}, {7'b0, e.ov});
    endtask

    task automatic classify(output logic ld);
        int n = m_buf.len();
        int last = -1;
        ld = 1'b1;
        if (m_buf == "OK") m_ctrl = 3'b001;
        else if (m_buf == "ERROR" || (n >= 11 && m_buf.substr(0, 10) == "+CMS ERROR:")) m_ctrl = 3'b011;
        else if (n >= 6 && m_buf.substr(0, 5) == "+CPMS:") m_ctrl = 3'b010;
        else if (n >= 6 && m_buf.substr(0, 5) == "+CMTI:") begin
            for (int i = 0; i < n; i++) if (m_buf[i] == ",") last = i;
            if (last >= 0 && n - last - 1 == 1 && m_buf[n-1] >= "0" && m_buf[n-1] <= "9") begin
                m_ctrl = 3'b100;
                m_msg  = m_buf[n-1];
            end else m_ctrl = 3'b101;
        end else ld = 1'b0;
    endtask

    task automatic step(input string tag, input logic [7:0] b, input bit v, input bit clr, input bit gap);
        exp_t e;
        e.ld = 1'b0;
        e.ov = 1'b0;
        if (clr) m_ctrl = 3'b000;
        if (v && b != 8'h0A) begin
            if (b == 8'h0D) begin
                if (!m_disc && m_buf.len() > 0) classify(e.ld);
                m_buf = "";
                m_disc = 0;
            end else if (!m_disc) begin
                if (m_buf.len() == MAXLEN) begin
                    m_disc = 1;
                    e.ov = 1'b1;
                end else m_buf = $sformatf("%s%c", m_buf, b);
            end
        end
        e.c = m_ctrl;
        e.m = m_msg;
        sb.push_back(e);
        rx_data = b;
        rx_valid = v;
        clear = clr;
        @(negedge clk);
        rx_valid = 1'b0;
        clear = 1'b0;
        pop_chk(tag);
        if (gap) begin
            @(negedge clk);
            chk({tag, "_gap_line_done"}, {7'b0, line_done}, 8'h00);
            chk({tag, "_gap_ovf"}, {7'b0, ovf}, 8'h00);
        end
    endtask

    task automatic send_str(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) step(tag, s[i], 1'b1, 1'b0, 1'b1);
    endtask

    task automatic send_line(input string tag, input string s);
        send_str(tag, s);
        step({tag, "_cr"}, 8'h0D, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        m_buf = "";
        m_disc = 0;
        m_ctrl = '0;
        m_msg = '0;
        e = '{c: 3'b000, m: 8'h00, ld: 1'b0, ov: 1'b0};
        sb.push_back(e);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pop_chk(tag);
        rst = 1'b1;
    endtask

    initial begin
        string a33;
        string p32;
        a33 = "";
        for (int i = 0; i < 33; i++) a33 = {a33, "A"};
        p32 = "+CPMS:";
        for (int i = 0; i < 26; i++) p32 = {p32, "x"};
        @(negedge clk);
        do_reset("reset");
        send_line("ok", "OK");
        step("lf", 8'h0A, 1'b1, 1'b0, 1'b1);
        send_line("cmti3", "+CMTI: \"SM\",3");
        step("clear", 8'h00, 1'b0, 1'b1, 1'b1);
        send_line("cmti12", "+CMTI: \"SM\",12");
        send_line("cms_err", "+CMS ERROR: 321");
        send_line("cmti9", "+CMTI: \"SM\",9");
        send_line("cmti_nocomma", "+CMTI: 7");
        send_line("cmti_empty", "+CMTI: \"SM\",");
        send_line("cmti_alpha", "+CMTI: \"SM\",x");
        send_line("ovf33", {a33, "OK"});
        send_line("ok_after_ovf", "OK");
        send_line("len32", p32);
        step("blank_cr", 8'h0D, 1'b1, 1'b0, 1'b1);
        send_line("echo", "AT+CMGD=1,4");
        send_line("lower_ok", "ok");
        send_line("ok_long", "OKK");
        send_line("error", "ERROR");
        send_str("cpms_clr", "+CPMS: 1,30");
        step("cpms_clr_cr", 8'h0D, 1'b1, 1'b1, 1'b1);
        send_str("b2b_ok", "OK");
        step("b2b_ok_cr", 8'h0D, 1'b1, 1'b0, 1'b0);
        send_line("b2b_err", "ERROR");
        send_str("mid", "+CP");
        do_reset("mid_reset");
        send_line("ok_post_reset", "OK");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/at_resp_decoder.md
AT_RESP_DECODER -- requirements
Module: at_resp_decoder

Interface
REQ-001 SHALL have parameter MAXLEN, default 32, meaning the maximum number of characters per response line, excluding CR.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port rx_data, input, 8 bits: a byte from the UART receiver.
REQ-005 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking rx_data as valid; the block accepts a byte on every strobe.
REQ-006 SHALL have port clear, input, 1 bit: acknowledge from the SMS sequencing FSM; returns ctrl to 000.
REQ-007 SHALL have port ctrl, output, 3 bits, with these codes:
- 000: none
- 001: OK
- 010: +CPMS:
- 011: ERROR
- 100: +CMTI: (new SMS)
- 101: malformed +CMTI:
REQ-008 SHALL have port msg_no, output, 8 bits: the ASCII digit of the SMS index from the last valid +CMTI: line.
REQ-009 SHALL have port line_done, output, 1 bit: one-cycle pulse when a recognised line is classified.
REQ-010 SHALL have port ovf, output, 1 bit: one-cycle pulse when a line exceeds MAXLEN.

Function
REQ-011 SHALL treat CR (0x0D) as the line terminator and ignore LF (0x0A) entirely; LF neither counts toward length nor is matched.
REQ-012 SHALL implement three states:
- IDLE: no characters in the current line.
- COLLECT: one or more characters received.
- DISCARD: the current line overflowed.
REQ-013 IDLE -> COLLECT on any non-CR, non-LF byte; a CR in IDLE (blank line) SHALL be ignored, with no pulse and ctrl unchanged.
REQ-014 SHALL classify incrementally: per character position, compare rx_data against each keyword; no line buffer is stored.
REQ-015 Classification SHALL be:
- Exact line "OK" -> 001.
- Exact line "ERROR", or any line with prefix "+CMS ERROR:" -> 011.
- Prefix "+CPMS:" -> 010.
- Prefix "+CMTI:" -> 100 or 101, per REQ-016.
- Matching is case-sensitive.
- Any other line (command echo, unsolicited text) is unrecognised: ctrl unchanged and no line_done pulse.
REQ-016 For a +CMTI: line, the index field SHALL be the characters after the last ',' in the line.
- Exactly one ASCII digit ('0'..'9') -> ctrl=100, and msg_no is loaded with that digit.
- Anything else (empty, a non-digit, or more than one character) -> ctrl=101, and msg_no is unchanged.
REQ-017 When CR is sampled in COLLECT with a recognised line, ctrl (and msg_no when applicable) SHALL update on that same clock edge, and line_done SHALL be high for exactly the following cycle; the state returns to IDLE.
REQ-018 Latency: one edge from the CR strobe to a valid ctrl; there is no dead time, so a byte on the cycle immediately after CR starts a new line.
REQ-019 The (MAXLEN+1)th non-LF character SHALL cause COLLECT -> DISCARD and a one-cycle ovf pulse in the following cycle. In DISCARD, all bytes are ignored until CR, which returns the state to IDLE with no line_done and ctrl unchanged.
REQ-020 ctrl SHALL hold its value until the next recognised line or clear. On a clear strobe, ctrl <= 000 at the next edge.
REQ-021 If clear and a line-completing CR occur on the same edge, the line result SHALL take priority.
REQ-022 Cycles with rx_valid low SHALL leave all state unchanged, except clear handling and pulse deassertion.
REQ-023 The character counter SHALL be width clog2(MAXLEN+2) and SHALL saturate; it never wraps.

Reset
REQ-024 While rst=0 at a rising edge, the block SHALL enter IDLE and reset all outputs:
- ctrl=000
- msg_no=0x00
- line_done=0
- ovf=0
- character counter and match flags cleared
REQ-025 A reset in the middle of a line SHALL discard that partial line; the first byte after reset release begins a new line.

Verification
REQ-026 Bytes "O","K",CR, then LF, with 1-cycle gaps -> ctrl=001 one edge after CR; line_done high for 1 cycle; LF causes no change.
REQ-027 Line "+CMTI: \"SM\",3" then CR -> ctrl=100, msg_no=0x33, line_done pulse. Then clear -> ctrl=000 next edge, msg_no stays 0x33.
REQ-028 Line "+CMTI: \"SM\",12" then CR -> ctrl=101, msg_no unchanged. Line "+CMS ERROR: 321" then CR -> ctrl=011.
REQ-029 33 'A' characters, then "OK", then CR, with MAXLEN=32 -> ovf pulse after the 33rd character; CR gives no line_done and ctrl unchanged. A following "OK"+CR line -> ctrl=001.
REQ-030 Echo line "AT+CMGD=1,4" then CR -> no pulse, ctrl unchanged. "+CPMS: 1,30" then CR with clear on the same edge -> ctrl=010.
REQ-031 rst=0 asserted after "+CP" -> outputs zeroed; then "OK"+CR after release -> ctrl=001.
